alu_pipe: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU.
- Generic WIDTH datapath with a valid/ready handshake on input and output.
- Status flags (carry, zero, negative, overflow, error) and an iterative multi-cycle multiply.
- Sits between the operand/opcode issue logic and the result writeback path.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 57 +++++
 rtl/alu_pipe.sv | 189 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHIFT = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_ROT   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_DEC   = 4'd10;
  localparam logic [3:0] OP_SLTU  = 4'd11;
  localparam logic [3:0] OP_SLT   = 4'd12;
  localparam logic [3:0] OP_PASS  = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int F_COUT = 0;
  localparam int F_ZERO = 1;
  localparam int F_NEG  = 2;
  localparam int F_OVF  = 3;
  localparam int F_ERR  = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier. The first partial product is folded into
// the start cycle so the full product is ready WIDTH cycles after start.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

  // One shift-add step: upper half accumulates, lower half shifts out the multiplier.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   mc);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  // Load-and-first-step on start, then WIDTH-1 further steps with a down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      product <= step({{WIDTH{1'b0}}, b}, a);
      cnt     <= CW'(WIDTH - 1);
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (busy) begin
      product <= step(product, mcand);
      cnt     <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and status flags.
// Build option ALU_PIPE_MUL_EN: when defined, opcode 14 runs the iterative
// multiplier; when undefined, opcode 14 is illegal (err=1, single cycle).
//
// state | meaning
// IDLE  | empty, ready for a new op
// MUL   | multiplier iterating, input stalled
// DONE  | result/flags presented, waiting for out_ready
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       s,
  input  logic [SHW-1:0]   shamt,
  input  logic             shdir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int M = WIDTH - 1;
  localparam logic [SHW:0] WFULL = (SHW+1)'(WIDTH);

  state_t state, state_n;
  logic   accept, is_mul;

  logic [WIDTH:0]        add_w, sub_w, inc_w, dec_w, shl_w, shr_w;
  logic signed [WIDTH:0] sra_w;
  logic [WIDTH-1:0]      rol_w, ror_w;
  logic [WIDTH-1:0]      res_c;
  logic                  cout_c, ovf_c, err_c;
  logic [4:0]            flags_c;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign add_w = {1'b0, x} + {1'b0, y};
  assign sub_w = {1'b0, x} - {1'b0, y};
  assign inc_w = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_w = {1'b0, x} - {{WIDTH{1'b0}}, 1'b1};
  // Extra bit beyond the shifted word holds the last bit shifted out.
  assign shl_w = {1'b0, x} << shamt;
  assign shr_w = {x, 1'b0} >> shamt;
  assign sra_w = $signed({x, 1'b0}) >>> shamt;
  assign rol_w = (x << shamt) | (x >> (WFULL - {1'b0, shamt}));
  assign ror_w = (x >> shamt) | (x << (WFULL - {1'b0, shamt}));

`ifdef ALU_PIPE_MUL_EN
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [4:0]         mul_flags;

  assign is_mul = (s == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (x),
    .b       (y),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Flags for the multiplier result; cout flags a truncated product.
  always_comb begin
    mul_flags         = '0;
    mul_flags[F_COUT] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[F_ZERO] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[F_NEG]  = mul_prod[M];
  end
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle op mux and its flags.
  always_comb begin
    res_c  = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    err_c  = 1'b0;
    case (s)
      OP_ADD: begin
        res_c  = add_w[M:0];
        cout_c = add_w[WIDTH];
        ovf_c  = (x[M] == y[M]) && (add_w[M] != x[M]);
      end
      OP_SUB: begin
        res_c  = sub_w[M:0];
        cout_c = sub_w[WIDTH];
        ovf_c  = (x[M] != y[M]) && (sub_w[M] != x[M]);
      end
      OP_AND: res_c = x & y;
      OP_OR:  res_c = x | y;
      OP_XOR: res_c = x ^ y;
      OP_NOT: res_c = ~x;
      OP_SHIFT: begin
        if (shdir) begin
          res_c  = shr_w[WIDTH:1];
          cout_c = shr_w[0];
        end else begin
          res_c  = shl_w[M:0];
          cout_c = shl_w[WIDTH];
        end
      end
      OP_SRA: begin
        res_c  = sra_w[WIDTH:1];
        cout_c = sra_w[0];
      end
      OP_ROT: begin
        res_c  = shdir ? ror_w : rol_w;
        cout_c = (|shamt) && (shdir ? ror_w[M] : rol_w[0]);
      end
      OP_INC: begin
        res_c  = inc_w[M:0];
        cout_c = inc_w[WIDTH];
        ovf_c  = !x[M] && inc_w[M];
      end
      OP_DEC: begin
        res_c  = dec_w[M:0];
        cout_c = dec_w[WIDTH];
        ovf_c  = x[M] && !dec_w[M];
      end
      OP_SLTU: res_c = {{M{1'b0}}, (x < y)};
      OP_SLT:  res_c = {{M{1'b0}}, ($signed(x) < $signed(y))};
      OP_PASS: res_c = y;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  res_c = '0;
`endif
      OP_RSVD: err_c = 1'b1;
      default: err_c = 1'b1;
    endcase
    flags_c         = '0;
    flags_c[F_COUT] = cout_c;
    flags_c[F_ZERO] = (res_c == '0) && !err_c;
    flags_c[F_NEG]  = res_c[M];
    flags_c[F_OVF]  = ovf_c;
    flags_c[F_ERR]  = err_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = is_mul ? MUL : DONE;
`ifdef ALU_PIPE_MUL_EN
      MUL:  if (mul_done && !mul_busy) state_n = DONE;
`else
      MUL:  state_n = IDLE;
`endif
      DONE: if (out_ready) state_n = accept ? (is_mul ? MUL : DONE) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result/flags register: loaded at accept for single-cycle ops or when the multiply completes; otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (accept && !is_mul) begin
      result <= res_c;
      flags  <= flags_c;
`ifdef ALU_PIPE_MUL_EN
    end else if (state == MUL && mul_done) begin
      result <= mul_prod[M:0];
      flags  <= mul_flags;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): the driver pushes hand-computed
// expectations at accept, a monitor pops and compares on each output handshake.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, shdir, out_valid, out_ready;
  logic [W-1:0] x, y, result;
  logic [3:0]   s;
  logic [2:0]   shamt;
  logic [4:0]   flags;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] r;
    logic [4:0]   f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wait_cycles = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .s         (s),
    .shamt     (shamt),
    .shdir     (shdir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  function automatic logic [4:0] fl(input logic e, input logic o, input logic n,
                                    input logic z, input logic c);
    return {e, o, n, z, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sa, input logic dir,
                       input logic [7:0] er, input logic [4:0] ef);
    int w;
    exp_t e;
    w = 0;
    in_valid = 1'b1; s = op; x = a; y = b; shamt = sa; shdir = dir;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout op%0d: in_ready stuck at 0 after %0d cycles", op, w);
    end else begin
      e.op = op; e.r = er; e.f = ef;
      sb.push_back(e);
    end
    wait_cycles += w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom); y = 8'($urandom); s = 4'($urandom);
    shamt = 3'($urandom); shdir = 1'($urandom);
  endtask

  // Called right after issue; counts cycles to out_valid and in_ready-low cycles.
  task automatic measure(input string name, input int exp_lat, input int exp_lo);
    int lat, lo;
    lat = 1; lo = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (!in_ready) lo++;
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " in_ready_low_cycles"}, 32'(lo), 32'(exp_lo));
    @(posedge clk); #1;
  endtask

  // Monitor: compare on every output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got result 0x%0h flags 0x%0h, expected no output", result, flags);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result op%0d", e.op), 32'(result), 32'(e.r));
          chk($sformatf("flags op%0d", e.op), 32'(flags), 32'(e.f));
        end
      end
    end
  end

  initial begin : driver
    int nv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; s = '0; shamt = '0; shdir = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back.
    issue(4'd0,  8'd200, 8'd100, 3'd0, 1'b0, 8'd44,  fl(0,0,0,0,1));
    issue(4'd1,  8'd5,   8'd10,  3'd0, 1'b0, 8'd251, fl(0,0,1,0,1));
    issue(4'd6,  8'd25,  8'd0,   3'd2, 1'b1, 8'd6,   fl(0,0,0,0,0));
    issue(4'd8,  8'h81,  8'd0,   3'd1, 1'b0, 8'h03,  fl(0,0,0,0,1));
    issue(4'd7,  8'h80,  8'd0,   3'd3, 1'b1, 8'hF0,  fl(0,0,1,0,0));
    issue(4'd7,  8'h83,  8'd0,   3'd1, 1'b0, 8'hC1,  fl(0,0,1,0,1));
    issue(4'd6,  8'hA5,  8'd0,   3'd0, 1'b0, 8'hA5,  fl(0,0,1,0,0));
    issue(4'd8,  8'hA5,  8'd0,   3'd0, 1'b1, 8'hA5,  fl(0,0,1,0,0));
    issue(4'd8,  8'h01,  8'd0,   3'd1, 1'b1, 8'h80,  fl(0,0,1,0,1));
    issue(4'd6,  8'h81,  8'd0,   3'd1, 1'b0, 8'h02,  fl(0,0,0,0,1));
    issue(4'd9,  8'hFF,  8'd0,   3'd0, 1'b0, 8'h00,  fl(0,0,0,1,1));
    issue(4'd9,  8'h7F,  8'd0,   3'd0, 1'b0, 8'h80,  fl(0,1,1,0,0));
    issue(4'd10, 8'h00,  8'd0,   3'd0, 1'b0, 8'hFF,  fl(0,0,1,0,1));
    issue(4'd1,  8'h80,  8'h01,  3'd0, 1'b0, 8'h7F,  fl(0,1,0,0,0));
    issue(4'd0,  8'h7F,  8'h01,  3'd0, 1'b0, 8'h80,  fl(0,1,1,0,0));
    issue(4'd2,  8'hF0,  8'h3C,  3'd0, 1'b0, 8'h30,  fl(0,0,0,0,0));
    issue(4'd3,  8'hF0,  8'h0F,  3'd0, 1'b0, 8'hFF,  fl(0,0,1,0,0));
    issue(4'd4,  8'hAA,  8'hAA,  3'd0, 1'b0, 8'h00,  fl(0,0,0,1,0));
    issue(4'd5,  8'h0F,  8'h00,  3'd0, 1'b0, 8'hF0,  fl(0,0,1,0,0));
    issue(4'd11, 8'd5,   8'd200, 3'd0, 1'b0, 8'd1,   fl(0,0,0,0,0));
    issue(4'd12, 8'd5,   8'd200, 3'd0, 1'b0, 8'd0,   fl(0,0,0,1,0));
    issue(4'd13, 8'h99,  8'h42,  3'd0, 1'b0, 8'h42,  fl(0,0,0,0,0));
    issue(4'd15, 8'h01,  8'h02,  3'd0, 1'b0, 8'h00,  fl(1,0,0,0,0));

    issue(4'd0, 8'd3, 8'd4, 3'd0, 1'b0, 8'd7, fl(0,0,0,0,0));
    measure("add", 1, 0);

`ifdef ALU_PIPE_MUL_EN
    issue(4'd14, 8'd20, 8'd7, 3'd0, 1'b0, 8'd140, fl(0,0,1,0,0));
    measure("mul20x7", W + 1, W);
    issue(4'd14, 8'd16, 8'd16, 3'd0, 1'b0, 8'd0, fl(0,0,0,1,1));
    measure("mul16x16", W + 1, W);
`else
    issue(4'd14, 8'd20, 8'd7, 3'd0, 1'b0, 8'd0, fl(1,0,0,0,0));
    measure("mul_illegal", 1, 0);
`endif

    // Backpressure: result must hold and input must stall.
    out_ready = 1'b0;
    issue(4'd0, 8'h10, 8'h20, 3'd0, 1'b0, 8'h30, fl(0,0,0,0,0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d result", i), 32'(result), 32'h30);
      chk($sformatf("bp%0d flags", i), 32'(flags), 32'd0);
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      x = 8'($urandom); y = 8'($urandom);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_cycles = 0;
    issue(4'd4, 8'h0F, 8'hFF, 3'd0, 1'b0, 8'hF0, fl(0,0,1,0,0));
    issue(4'd0, 8'd1,  8'd2,  3'd0, 1'b0, 8'd3,  fl(0,0,0,0,0));
    issue(4'd1, 8'd3,  8'd3,  3'd0, 1'b0, 8'd0,  fl(0,0,0,1,0));
    issue(4'd5, 8'hFF, 8'd0,  3'd0, 1'b0, 8'd0,  fl(0,0,0,1,0));
    chk("back_to_back stall cycles", 32'(wait_cycles), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset while an op is in flight: no result may come out.
`ifdef ALU_PIPE_MUL_EN
    issue(4'd14, 8'd3, 8'd3, 3'd0, 1'b0, 8'd9, fl(0,0,0,0,0));
`else
    out_ready = 1'b0;
    issue(4'd0, 8'd1, 8'd1, 3'd0, 1'b0, 8'd2, fl(0,0,0,0,0));
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort result", 32'(result), 32'd0);
    chk("abort flags", 32'(flags), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("post_abort outputs", 32'(nv), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
